multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/mem_wait_counter.sv | 21 ++
 rtl/multicycle_controller.sv | 126 ++++++++++++
 tb/tb_multicycle_controller.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU controller: state encoding,
// instruction classes and the result/ALU-B mux select constants.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB,
    MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
  } stateT;

  localparam logic [1:0] OP_DP  = 2'd0;
  localparam logic [1:0] OP_MEM = 2'd1;
  localparam logic [1:0] OP_BR  = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating wait counter: cleared on state entry, counts up to loadValue
// and then holds, raising done while it sits at loadValue.
module mem_wait_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [CNT_W-1:0] loadValue,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == loadValue);

  always_ff @(posedge clk) begin
    if (clear)      cnt <= '0;
    else if (!done) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU main controller: Moore FSM sequencing fetch/decode/execute
// with MEM_LAT extra wait cycles on every memory access.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic       I,
  input  logic       L,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWR,
  output logic       RegWR,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic       Branch,
  output logic [1:0] InmSrc,
  output logic [1:0] RegSrc,
  output logic       Illegal
);

  stateT state, nextState;
  logic  waitDone, illegalQ;

  // Clearing on any state change restarts the wait count on every entry.
  mem_wait_counter #(.CNT_W(CNT_W)) waitCnt (
    .clk      (clk),
    .clear    (reset || (nextState != state)),
    .loadValue(CNT_W'(MEM_LAT)),
    .done     (waitDone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      illegalQ <= 1'b0;
    end else begin
      state    <= nextState;
      illegalQ <= (state == DECODE) && (Op == OP_ILL);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:    if (waitDone) nextState = DECODE;
      DECODE: begin
        case (Op)
          OP_DP:   nextState = I ? EXECI : EXECR;
          OP_MEM:  nextState = MEMADR;
          OP_BR:   nextState = BRANCH;
          default: nextState = FETCH;
        endcase
      end
      MEMADR:   nextState = L ? MEMREAD : MEMWRITE;
      MEMREAD:  if (waitDone) nextState = MEMWB;
      MEMWRITE: if (waitDone) nextState = FETCH;
      EXECR,
      EXECI:    nextState = ALUWB;
      default:  nextState = FETCH;
    endcase
  end

  // Write strobes are masked while reset is held so nothing commits.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWR     = 1'b0;
    RegWR     = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ALUOp     = 1'b0;
    Branch    = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = waitDone && !reset;
        PCWrite   = waitDone && !reset;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR:   ALUSrcB = SRCB_IMM;
      EXECI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      EXECR:    ALUOp = 1'b1;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemWR  = !reset;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWR     = !reset;
      end
      ALUWB:    RegWR = !reset;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign Illegal   = illegalQ;
  assign InmSrc    = Op;
  assign RegSrc[0] = (Op == OP_BR);
  assign RegSrc[1] = (Op == OP_MEM) && !L;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each instruction expands to its expected per-cycle
// control words; a negedge monitor pops and compares against the DUT.
module tb_multicycle_controller;
  localparam int LAT = 2;

  logic       clk = 1'b0, reset = 1'b1;
  logic [1:0] Op = 2'd0;
  logic       I = 1'b0, L = 1'b0;
  logic       PCWrite, AdrSrc, IRWrite, MemWR, RegWR, ALUSrcA, ALUOp, Branch, Illegal;
  logic [1:0] ResultSrc, ALUSrcB, InmSrc, RegSrc;

  multicycle_controller #(.MEM_LAT(LAT), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .Op(Op), .I(I), .L(L),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWR(MemWR),
    .RegWR(RegWR), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .Branch(Branch), .InmSrc(InmSrc), .RegSrc(RegSrc),
    .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // phases of instruction execution
  localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMWB = 4, PMW = 5,
                 PER = 6, PEI = 7, PAWB = 8, PBR = 9;

  logic [12:0] expQ[$];
  int nChecks = 0, nFails = 0;
  bit illPending = 0;

  // {PCWrite,AdrSrc,IRWrite,MemWR,RegWR,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,Branch,Illegal}
  function automatic logic [12:0] vec(int ph, bit last);
    logic pcw = 0, adr = 0, irw = 0, mw = 0, rw = 0, a = 0, aop = 0, br = 0;
    logic [1:0] rs = 2'b00, b = 2'b00;
    case (ph)
      PF:   begin a = 1; b = 2'b10; rs = 2'b10; irw = last; pcw = last; end
      PD:   begin a = 1; b = 2'b10; rs = 2'b10; end
      PMA:  b = 2'b01;
      PEI:  begin b = 2'b01; aop = 1; end
      PER:  aop = 1;
      PMR:  adr = 1;
      PMW:  begin adr = 1; mw = 1; end
      PMWB: begin rs = 2'b01; rw = 1; end
      PAWB: rw = 1;
      PBR:  begin b = 2'b01; rs = 2'b10; br = 1; end
      default: ;
    endcase
    return {pcw, adr, irw, mw, rw, rs, a, b, aop, br, 1'b0};
  endfunction

  task automatic pushPhase(int ph, int n, inout int cycles);
    logic [12:0] v;
    for (int k = 0; k < n; k++) begin
      v = vec(ph, k == n - 1);
      if (illPending) begin v[0] = 1'b1; illPending = 0; end
      expQ.push_back(v);
      cycles++;
    end
  endtask

  task automatic runInstr(logic [1:0] op, logic imm, logic ld);
    int n = 0;
    Op = op; I = imm; L = ld;
    pushPhase(PF, LAT + 1, n);
    pushPhase(PD, 1, n);
    case (op)
      2'd0: begin pushPhase(imm ? PEI : PER, 1, n); pushPhase(PAWB, 1, n); end
      2'd1: begin
        pushPhase(PMA, 1, n);
        if (ld) begin pushPhase(PMR, LAT + 1, n); pushPhase(PMWB, 1, n); end
        else    pushPhase(PMW, LAT + 1, n);
      end
      2'd2: pushPhase(PBR, 1, n);
      default: illPending = 1;
    endcase
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [12:0] e, act;
    logic [1:0]  eRegSrc;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      act = {PCWrite, AdrSrc, IRWrite, MemWR, RegWR, ResultSrc, ALUSrcA, ALUSrcB,
             ALUOp, Branch, Illegal};
      nChecks++;
      if (act !== e) begin
        nFails++;
        $display("FAIL ctrlWord t=%0t got=%b expected=%b", $time, act, e);
      end
      nChecks++;
      if (InmSrc !== Op) begin
        nFails++;
        $display("FAIL InmSrc t=%0t got=%b expected=%b", $time, InmSrc, Op);
      end
      eRegSrc = {(Op == 2'd1) && !L, Op == 2'd2};
      nChecks++;
      if (RegSrc !== eRegSrc) begin
        nFails++;
        $display("FAIL RegSrc t=%0t got=%b expected=%b", $time, RegSrc, eRegSrc);
      end
    end
  end

  initial begin
    int n;
    @(posedge clk); #1;
    n = 0;
    pushPhase(PF, 1, n);            // reset held: FETCH muxes, no strobes
    pushPhase(PF, 1, n);
    expQ[0] = vec(PF, 0);
    expQ[1] = vec(PF, 0);
    repeat (2) @(posedge clk); #1;
    reset = 0;

    runInstr(2'd0, 1'b0, 1'b0);
    runInstr(2'd0, 1'b1, 1'b1);
    runInstr(2'd1, 1'b0, 1'b1);
    runInstr(2'd1, 1'b1, 1'b0);
    runInstr(2'd1, 1'b0, 1'b0);
    runInstr(2'd2, 1'b1, 1'b1);
    runInstr(2'd3, 1'b0, 1'b0);
    runInstr(2'd0, 1'b0, 1'b1);
    runInstr(2'd3, 1'b1, 1'b1);
    runInstr(2'd3, 1'b0, 1'b1);
    runInstr(2'd2, 1'b0, 1'b0);

    // reset in the middle of a load's memory wait
    Op = 2'd1; I = 1'b0; L = 1'b1;
    n = 0;
    pushPhase(PF, LAT + 1, n);
    pushPhase(PD, 1, n);
    pushPhase(PMA, 1, n);
    pushPhase(PMR, 1, n);
    expQ.push_back(vec(PMR, 0));
    repeat (n) @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    runInstr(2'd1, 1'b0, 1'b1);

    for (int k = 0; k < 40; k++)
      runInstr(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("FAIL drain got=%0d pending expected=0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
